hilo_muldiv_unit: RTL
=====================

# hilo_muldiv_unit

Parametrised iterative multiply/divide unit owning the HI/LO architectural registers, the next-generation replacement for the single-cycle HI/LO path inside the pipeline's ALU. It sits beside the EX-stage ALU: EX issues an operation with a one-cycle Start pulse, the unit runs multi-cycle and holds Busy, and hazard detection stalls any HI/LO reader (MFHI/MFLO) or new HI/LO operation while Busy is high. Supports signed/unsigned multiply and divide, multiply-accumulate/subtract, direct HI/LO writes, divide-by-zero reporting and pipeline flush.

## Interface
- WIDTH, 32, operand and HI/LO width in bits; must be even and ≥ 4.
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- Start  in  1  one-cycle operation request; sampled only when Busy=0.
- Op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD (signed), 5 MSUB (signed), 6 MTHI, 7 MTLO.
- A  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- B  in  WIDTH  rt operand (multiplier / divisor).
- Flush  in  1  abort the in-flight operation.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle completion pulse.
- DivZero  out  1  one-cycle pulse, coincident with Done, for DIV/DIVU with B=0.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIXUP. Reset → IDLE; Hi=Lo=0, Busy=Done=DivZero=0.
- IDLE + Start, Op ∈ {0..5}, not divide-by-zero: latch operands as magnitudes (signed ops take absolute value, record result sign), clear step counter → RUN.
- RUN: one radix-2 step per cycle (shift-add multiply, restoring divide), counter increments; after WIDTH steps → FIXUP.
- FIXUP: apply sign correction; MULT/MULTU write {Hi,Lo}=2·WIDTH-bit product; MADD/MSUB write {Hi,Lo} = {Hi,Lo} ± signed product (modulo 2^(2·WIDTH)); DIV/DIVU write Lo=quotient, Hi=remainder → IDLE with Done=1.
- Signed divide: quotient truncates toward zero, remainder takes dividend sign. Most-negative / −1: Lo=most-negative (wraps), Hi=0, no error flag.
- DIV/DIVU with B=0: no RUN; next cycle Done=1, DivZero=1, Hi/Lo unchanged.
- MTHI/MTLO: Hi (resp. Lo) ← A at the Start edge; next cycle Done=1; Busy never asserted.
- Start while Busy=1: ignored, no effect on in-flight operation.
- Flush in RUN or FIXUP: → IDLE next edge, Hi/Lo unchanged, no Done. Flush in IDLE with Start: Start ignored. Flush wins over completion in FIXUP.
- Reset mid-operation: same as Reset from any state (Hi/Lo cleared).

## Timing
- Start sampled in cycle T. Long ops: Busy=1 in cycles T+1..T+WIDTH+1; Done=1 and new Hi/Lo visible in cycle T+WIDTH+2 (T+34 for WIDTH=32); Busy=0 in that cycle so a new Start may be issued there.
- MTHI/MTLO and divide-by-zero: Done (and DivZero) in cycle T+1; MTHI/MTLO value visible in T+1.
- Done, DivZero are registered, exactly one cycle wide; Hi/Lo are registered and change only on completion edges, MTHI/MTLO, or Reset.
- MADD/MSUB read Hi/Lo at FIXUP, so intermediate MTHI/MTLO cannot occur (unit Busy).

## Test plan
- Reset, then MULT A=7, B=0xFFFFFFFD (−3) at T → Busy T+1..T+33, Done at T+34, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- DIVU A=100, B=7 → Lo=14, Hi=2; DIV A=0xFFFFFFF9 (−7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
- MTHI 0, MTLO 10, then MADD A=3, B=4 → Lo=22, Hi=0; then MSUB A=5, B=5 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- MTLO 0x1234, then DIV A=5, B=0 → Done and DivZero high one cycle at T+1, Lo=0x1234 unchanged.
- MULTU 0xFFFFFFFF×0xFFFFFFFF, second Start (DIVU) at T+5 ignored, Flush at T+10 → Busy low at T+11, no Done, Hi/Lo keep prior values.
- WIDTH=8 instance: MULT 0x80×0x80 → Hi=0x40, Lo=0x00, Done at T+10; Reset asserted at T+4 of a DIVU → Hi=Lo=0, Busy=0 next cycle.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative radix-2 multiply/divide unit owning the HI/LO registers
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;
    state_t             state;
    logic [2:0]         op_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] p;
    logic               neg_q;
    logic               neg_r;
    logic               is_signed;
    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    // operand magnitudes, one shift-add / restoring-divide step, and sign-corrected results
    always_comb begin
        is_signed = op == 3'd0 || op == 3'd2 || op == 3'd4 || op == 3'd5;
        is_div    = op == 3'd2 || op == 3'd3;
        a_neg     = is_signed && a[WIDTH-1];
        b_neg     = is_signed && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
        div_shift = p[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, m};
        step      = op_q[2:1] == 2'b01
                  ? (div_diff[WIDTH] ? {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1})
                  : {mul_sum, p[WIDTH-1:1]};
        prod      = neg_q ? -p : p;
        acc       = op_q == 3'd5 ? {hi, lo} - prod : {hi, lo} + prod;
        quo       = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem       = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end
    // control FSM with registered busy/done/div_zero and HI/LO ownership
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            op_q     <= '0;
            cnt      <= '0;
            m        <= '0;
            p        <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: if (start && !flush) begin
                    if (op == 3'd6) begin
                        hi   <= a;
                        done <= 1'b1;
                    end else if (op == 3'd7) begin
                        lo   <= a;
                        done <= 1'b1;
                    end else if (is_div && b == '0) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end else begin
                        state <= RUN;
                        busy  <= 1'b1;
                        op_q  <= op;
                        cnt   <= '0;
                        m     <= is_div ? b_mag : a_mag;
                        p     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                    end
                end
                RUN: if (flush) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    p   <= step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIXUP;
                end
                FIXUP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done <= 1'b1;
                        if (op_q[2:1] == 2'b01) begin
                            lo <= quo;
                            hi <= rem;
                        end else if (op_q[2]) begin
                            {hi, lo} <= acc;
                        end else begin
                            {hi, lo} <= prod;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
